// File: rtl/tally_arbiter.sv
// tally_arbiter: 8-bit saturating score driven by auto-repeating buttons (port A) and a
// valid/ready command port (port B), with round-robin arbitration between the two.
module tally_arbiter #(
    parameter int REPEAT_DELAY = 12500000,
    parameter int REPEAT_RATE  = 2500000
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Btn_Inc,
    input  logic       i_Btn_Dec,
    input  logic       i_Btn_Clr,
    input  logic       i_Cmd_Valid,
    input  logic [1:0] i_Cmd_Op,
    output logic       o_Cmd_Ready,
    output logic [7:0] o_Score,
    output logic       o_Sat
);
    localparam int CW = $clog2(REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE);
    localparam logic [1:0] OP_NOP = 2'b00, OP_INC = 2'b01, OP_DEC = 2'b10, OP_CLR = 2'b11;
    typedef enum logic [1:0] {IDLE, WAIT, REPEAT} rep_t;

    logic [2:0]    btn, btn_q, btn_p, arm_q, ev;
    logic [1:0]    go, rep;
    rep_t          st_q [2];
    rep_t          st_d [2];
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];
    logic          pend_a, last_b, grant_a, grant_b, ri, rd, sat_d;
    logic [1:0]    op_a, new_op, op;
    logic [7:0]    score_d;

    assign btn = {i_Btn_Clr, i_Btn_Dec, i_Btn_Inc};
    // A button held through reset stays disarmed until it has been seen released.
    assign ev = btn_q & ~btn_p & arm_q;
    assign go = {ev[1] & ~ev[0] & ~ev[2], ev[0] & ~ev[1] & ~ev[2]};

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            st_d[i]  = st_q[i];
            cnt_d[i] = cnt_q[i] + 1'b1;
            rep[i]   = 1'b0;
            if (!btn_q[i]) begin
                st_d[i]  = IDLE;
                cnt_d[i] = '0;
            end else if (st_q[i] == IDLE) begin
                cnt_d[i] = '0;
                if (go[i]) st_d[i] = WAIT;
            end else if (st_q[i] == WAIT && cnt_q[i] == CW'(REPEAT_DELAY - 1)) begin
                st_d[i]  = REPEAT;
                cnt_d[i] = '0;
                rep[i]   = 1'b1;
            end else if (st_q[i] == REPEAT && cnt_q[i] == CW'(REPEAT_RATE - 1)) begin
                cnt_d[i] = '0;
                rep[i]   = 1'b1;
            end
        end
    end

    assign ri          = ev[0] | rep[0];
    assign rd          = ev[1] | rep[1];
    assign new_op      = ev[2] ? OP_CLR : (ri & rd) ? OP_NOP : ri ? OP_INC : rd ? OP_DEC : OP_NOP;
    assign o_Cmd_Ready = ~(pend_a & last_b);
    assign grant_a     = pend_a & (~i_Cmd_Valid | last_b);
    assign grant_b     = i_Cmd_Valid & o_Cmd_Ready;
    assign op          = grant_a ? op_a : grant_b ? i_Cmd_Op : OP_NOP;
    assign sat_d       = (op == OP_INC && o_Score == 8'hff) || (op == OP_DEC && o_Score == 8'h00);
    assign score_d     = op == OP_CLR ? 8'h00 : sat_d ? o_Score :
                         op == OP_INC ? o_Score + 8'd1 : op == OP_DEC ? o_Score - 8'd1 : o_Score;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            btn_q    <= '0;
            btn_p    <= '0;
            arm_q    <= '0;
            st_q[0]  <= IDLE;
            st_q[1]  <= IDLE;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
            pend_a   <= 1'b0;
            op_a     <= OP_NOP;
            last_b   <= 1'b1;
            o_Score  <= 8'h00;
            o_Sat    <= 1'b0;
        end else begin
            btn_q    <= btn;
            btn_p    <= btn_q;
            arm_q    <= arm_q | ~btn;
            st_q[0]  <= st_d[0];
            st_q[1]  <= st_d[1];
            cnt_q[0] <= cnt_d[0];
            cnt_q[1] <= cnt_d[1];
            o_Score  <= score_d;
            o_Sat    <= sat_d;
            last_b   <= grant_a ? 1'b0 : grant_b ? 1'b1 : last_b;
            if (new_op != OP_NOP && (!pend_a || grant_a)) begin
                pend_a <= 1'b1;
                op_a   <= new_op;
            end else if (grant_a) begin
                pend_a <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_tally_arbiter.sv
// tb_tally_arbiter: directed scenarios plus random traffic, checked every cycle against a
// behavioural model that derives auto-repeat timing arithmetically from hold duration.
module tb_tally_arbiter;
    localparam int DELAY = 20;
    localparam int RATE  = 5;

    logic       i_Clk = 1'b0;
    logic       i_Rst_L;
    logic       i_Btn_Inc, i_Btn_Dec, i_Btn_Clr, i_Cmd_Valid;
    logic [1:0] i_Cmd_Op;
    logic       o_Cmd_Ready, o_Sat;
    logic [7:0] o_Score;

    int n_chk  = 0;
    int n_fail = 0;

    bit m_lvl [3];
    bit m_prev[3];
    bit m_arm [3];
    int m_hold[2];
    bit m_pend, m_lastb, m_sat;
    int m_pop, m_score;

    tally_arbiter #(.REPEAT_DELAY(DELAY), .REPEAT_RATE(RATE)) dut (
        .i_Clk      (i_Clk),
        .i_Rst_L    (i_Rst_L),
        .i_Btn_Inc  (i_Btn_Inc),
        .i_Btn_Dec  (i_Btn_Dec),
        .i_Btn_Clr  (i_Btn_Clr),
        .i_Cmd_Valid(i_Cmd_Valid),
        .i_Cmd_Op   (i_Cmd_Op),
        .o_Cmd_Ready(o_Cmd_Ready),
        .o_Score    (o_Score),
        .o_Sat      (o_Sat)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_lvl[i]  = 0;
            m_prev[i] = 0;
            m_arm[i]  = 0;
        end
        m_hold[0] = -1;
        m_hold[1] = -1;
        m_pend    = 0;
        m_pop     = 0;
        m_lastb   = 1;
        m_sat     = 0;
        m_score   = 0;
    endtask

    // One clock of the model: inputs are whatever was presented at this rising edge.
    task automatic model_step();
        logic [2:0] raw;
        bit ev[3];
        bit rq[2];
        bit go[2];
        bit ga, gb;
        int new_op, op;
        raw = {i_Btn_Clr, i_Btn_Dec, i_Btn_Inc};
        for (int i = 0; i < 3; i++) ev[i] = m_lvl[i] && !m_prev[i] && m_arm[i];
        go[0] = ev[0] && !ev[1] && !ev[2];
        go[1] = ev[1] && !ev[0] && !ev[2];
        for (int i = 0; i < 2; i++)
            rq[i] = ev[i] || (m_lvl[i] && m_hold[i] >= DELAY && (m_hold[i] - DELAY) % RATE == 0);
        new_op = ev[2] ? 3 : (rq[0] && rq[1]) ? 0 : rq[0] ? 1 : rq[1] ? 2 : 0;
        ga = m_pend && (!i_Cmd_Valid || m_lastb);
        gb = i_Cmd_Valid && !(m_pend && m_lastb);
        op = ga ? m_pop : gb ? int'(i_Cmd_Op) : 0;
        m_sat = (op == 1 && m_score == 255) || (op == 2 && m_score == 0);
        if (op == 3) m_score = 0;
        else if (!m_sat && op == 1) m_score++;
        else if (!m_sat && op == 2) m_score--;
        if (new_op != 0 && (!m_pend || ga)) begin
            m_pend = 1;
            m_pop  = new_op;
        end else if (ga) begin
            m_pend = 0;
        end
        if (ga) m_lastb = 0;
        else if (gb) m_lastb = 1;
        for (int i = 0; i < 2; i++)
            m_hold[i] = !m_lvl[i] ? -1 : m_hold[i] >= 0 ? m_hold[i] + 1 : go[i] ? 1 : -1;
        for (int i = 0; i < 3; i++) begin
            m_arm[i]  = m_arm[i] || !raw[i];
            m_prev[i] = m_lvl[i];
            m_lvl[i]  = raw[i];
        end
    endtask

    task automatic tick();
        @(posedge i_Clk);
        if (i_Rst_L) model_step();
        else model_reset();
        @(negedge i_Clk);
        chk("score", 32'(o_Score), 32'(m_score));
        chk("sat", 32'(o_Sat), 32'(m_sat));
        chk("ready", 32'(o_Cmd_Ready), 32'(!(m_pend && m_lastb)));
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_reset();
        i_Rst_L = 1'b0;
        model_reset();
        run(2);
        i_Rst_L = 1'b1;
        run(2);
    endtask

    task automatic cmd(input logic [1:0] o, input int n);
        i_Cmd_Valid = 1'b1;
        i_Cmd_Op    = o;
        run(n);
        i_Cmd_Valid = 1'b0;
        i_Cmd_Op    = 2'b00;
    endtask

    initial begin
        int r;
        i_Rst_L     = 1'b0;
        i_Btn_Inc   = 1'b0;
        i_Btn_Dec   = 1'b0;
        i_Btn_Clr   = 1'b0;
        i_Cmd_Valid = 1'b1;
        i_Cmd_Op    = 2'b01;
        model_reset();
        #3;
        chk("reset_score", 32'(o_Score), 0);
        chk("reset_ready", 32'(o_Cmd_Ready), 1);
        run(2);
        chk("reset_ignores_cmd", 32'(o_Score), 0);
        i_Rst_L     = 1'b1;
        i_Cmd_Valid = 1'b0;
        i_Cmd_Op    = 2'b00;
        run(2);

        // Short press: single increment, no repeat.
        i_Btn_Inc = 1'b1;
        run(10);
        i_Btn_Inc = 1'b0;
        run(30);
        chk("single_press", 32'(o_Score), 1);

        // Long hold: 1 + six auto-repeats.
        do_reset();
        i_Btn_Inc = 1'b1;
        run(50);
        i_Btn_Inc = 1'b0;
        run(5);
        chk("repeat_hold", 32'(o_Score), 7);

        // Saturation at both limits.
        cmd(2'b01, 248);
        chk("reach_255", 32'(o_Score), 255);
        cmd(2'b01, 1);
        chk("sat_hi_pulse", 32'(o_Sat), 1);
        chk("sat_hi_score", 32'(o_Score), 255);
        tick();
        chk("sat_hi_drop", 32'(o_Sat), 0);
        cmd(2'b11, 1);
        chk("clr_score", 32'(o_Score), 0);
        chk("clr_no_sat", 32'(o_Sat), 0);
        cmd(2'b10, 1);
        chk("sat_lo_pulse", 32'(o_Sat), 1);
        chk("sat_lo_score", 32'(o_Score), 0);
        tick();
        chk("sat_lo_drop", 32'(o_Sat), 0);

        // Contention: A wins first after reset, then B.
        do_reset();
        cmd(2'b01, 5);
        chk("pre_contend", 32'(o_Score), 5);
        i_Btn_Inc = 1'b1;
        run(2);
        chk("ready_low", 32'(o_Cmd_Ready), 0);
        i_Cmd_Valid = 1'b1;
        i_Cmd_Op    = 2'b10;
        tick();
        chk("a_first", 32'(o_Score), 6);
        chk("ready_back", 32'(o_Cmd_Ready), 1);
        tick();
        chk("b_second", 32'(o_Score), 5);
        i_Cmd_Valid = 1'b0;
        i_Btn_Inc   = 1'b0;
        run(3);

        // Clear beats a simultaneous inc and suppresses its repeat.
        do_reset();
        cmd(2'b01, 9);
        chk("pre_clr", 32'(o_Score), 9);
        i_Btn_Clr = 1'b1;
        i_Btn_Inc = 1'b1;
        run(40);
        chk("clr_wins", 32'(o_Score), 0);
        i_Btn_Clr = 1'b0;
        i_Btn_Inc = 1'b0;
        run(3);

        // Reset mid-repeat, then held button stays silent until re-pressed.
        do_reset();
        cmd(2'b01, 20);
        i_Btn_Dec = 1'b1;
        run(30);
        chk("dec_repeat", 32'(o_Score), 17);
        #2;
        i_Rst_L = 1'b0;
        model_reset();
        #1;
        chk("async_reset", 32'(o_Score), 0);
        @(negedge i_Clk);
        run(3);
        i_Rst_L = 1'b1;
        cmd(2'b01, 3);
        run(37);
        chk("held_silent", 32'(o_Score), 3);
        i_Btn_Dec = 1'b0;
        run(2);
        i_Btn_Dec = 1'b1;
        run(3);
        i_Btn_Dec = 1'b0;
        run(2);
        chk("repress_dec", 32'(o_Score), 2);

        // Random traffic against the model.
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 15) == 0) i_Btn_Inc = ~i_Btn_Inc;
            if ($urandom_range(0, 15) == 0) i_Btn_Dec = ~i_Btn_Dec;
            if ($urandom_range(0, 31) == 0) i_Btn_Clr = ~i_Btn_Clr;
            r = $urandom_range(0, 9);
            i_Cmd_Valid = $urandom_range(0, 2) == 0;
            i_Cmd_Op    = r < 5 ? 2'b01 : r < 8 ? 2'b10 : r < 9 ? 2'b00 : 2'b11;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
